// File: rtl/uart_tx_serializer_if.sv
// Producer-side word handshake for uart_tx_serializer: one word moves per
// cycle where tx_valid and tx_ready are both high at a rising edge.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits. Define PARITY_EN to insert the parity bit after the data.
module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_serializer_if.slave        bus,
    output logic                       txd,
    output logic                       busy,
    output logic                       tx_done
);
    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("uart_tx_serializer: CLK_DIV must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_serializer: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic                 parity_reg;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_reg;
    logic [BAUD_W-1:0]    baud_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 txd_reg;
    logic                 ready_reg;
    logic                 busy_reg;
    logic                 done_reg;

    // txd is produced one edge ahead: each transition loads the level of the
    // bit that starts in the following cycle, so the pin is a plain flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (state_reg != IDLE) begin
                baud_reg <= (baud_reg == BAUD_LAST) ? '0 : baud_reg + BAUD_ONE;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.tx_valid && ready_reg) begin
                        shift_reg <= bus.tx_data;
`ifdef PARITY_EN
                        parity_reg <= (^bus.tx_data) ^ (PARITY_ODD != 0);
`endif
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        txd_reg   <= 1'b0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_reg == BAUD_LAST) begin
                        txd_reg   <= shift_reg[0];
                        bit_reg   <= '0;
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (baud_reg == BAUD_LAST) begin
                        if (bit_reg == DATA_LAST) begin
                            bit_reg <= '0;
`ifdef PARITY_EN
                            txd_reg   <= parity_reg;
                            state_reg <= PARITY;
`else
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
`endif
                        end else begin
                            bit_reg   <= bit_reg + BIT_ONE;
                            txd_reg   <= shift_reg[1];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (baud_reg == BAUD_LAST) begin
                        txd_reg   <= 1'b1;
                        bit_reg   <= '0;
                        state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Flag raised one edge early so the pulse lands on the final stop cycle.
                    if (baud_reg == BAUD_PRE && bit_reg == STOP_LAST) begin
                        done_reg <= 1'b1;
                    end
                    if (baud_reg == BAUD_LAST) begin
                        if (bit_reg == STOP_LAST) begin
                            bit_reg   <= '0;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            bit_reg <= bit_reg + BIT_ONE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready = ready_reg;
    assign txd          = txd_reg;
    assign busy         = busy_reg;
    assign tx_done      = done_reg;
endmodule
